// File: rtl/skip_pkg.sv
// Shared types and helpers for the skip-clock link receive side.
package skip_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HUNT    = 2'd1,
    COLLECT = 2'd2
  } state_t;

  localparam int SKIP_LEN_DEF = 16;

  // Frame index runs 0..len inclusive, so it needs room for len itself.
  function automatic int idx_w(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/skip_sync.sv
// Two-flop synchronizer for one async input, plus a rise pulse on the synced value.
module skip_sync (
  input  logic mCLK,
  input  logic nRST,
  input  logic d,
  output logic q,
  output logic rise
);

  logic s1, s2, s3;

  always_ff @(posedge mCLK or negedge nRST) begin
    if (!nRST) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign q    = s2;
  assign rise = s2 & ~s3;

endmodule

// File: rtl/skip_decode.sv
// Recovers the LEN-bit skip mask from SCLK/REF_CLK/B0 oversampled in mCLK.
// Optional popcount output enabled by defining SKIP_DECODE_CNT_EN.
module skip_decode
  import skip_pkg::*;
#(
  parameter int LEN        = SKIP_LEN_DEF,
  parameter int SAMPLE_DLY = 8,
  parameter int TIMEOUT    = 67108864
) (
  input  logic                     mCLK,
  input  logic                     nRST,
  input  logic                     REF_CLK,
  input  logic                     SCLK,
  input  logic                     B0,
  output logic [LEN-1:0]           MASK,
  output logic                     VALID,
  output logic                     LOCKED,
  output logic                     SYNC_ERR,
  output logic [$clog2(LEN+1)-1:0] SKIP_CNT
);

  localparam int IW = idx_w(LEN);
  localparam int DW = $clog2(SAMPLE_DLY + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = $clog2(LEN + 1);

  logic ref_s, ref_rise, sclk_s, b0_s;
  logic sclk_rise_unused, b0_rise_unused;

  skip_sync u_sync_ref  (.mCLK(mCLK), .nRST(nRST), .d(REF_CLK), .q(ref_s),  .rise(ref_rise));
  skip_sync u_sync_sclk (.mCLK(mCLK), .nRST(nRST), .d(SCLK),    .q(sclk_s), .rise(sclk_rise_unused));
  skip_sync u_sync_b0   (.mCLK(mCLK), .nRST(nRST), .d(B0),      .q(b0_s),   .rise(b0_rise_unused));

  logic [DW-1:0]  dly_cnt;
  logic           pending;
  logic [TW-1:0]  to_cnt;
  state_t         state_q, state_d;
  logic [IW-1:0]  idx_q;
  logic [LEN-1:0] shadow_q;
  logic           have_prev;

  logic sample, timeout, bit_v, mark;
  logic realign, store, frame_done, sync_evt;

  // A new REF rise wins over a sample that would land in the same cycle.
  assign sample  = pending && (dly_cnt == '0) && !ref_rise;
  assign timeout = (to_cnt == TW'(TIMEOUT)) && (state_q != IDLE) && !ref_rise;
  assign bit_v   = ~sclk_s;
  assign mark    = b0_s;

  always_ff @(posedge mCLK or negedge nRST) begin
    if (!nRST) begin
      dly_cnt <= '0;
      pending <= 1'b0;
      to_cnt  <= '0;
    end else begin
      if (ref_rise) begin
        dly_cnt <= DW'(SAMPLE_DLY - 1);
        pending <= 1'b1;
      end else if (pending) begin
        if (dly_cnt == '0) pending <= 1'b0;
        else               dly_cnt <= dly_cnt - DW'(1);
      end
      if (ref_rise)                    to_cnt <= '0;
      else if (to_cnt != TW'(TIMEOUT)) to_cnt <= to_cnt + TW'(1);
    end
  end

  always_ff @(posedge mCLK or negedge nRST) begin
    if (!nRST) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ref_rise) state_d = HUNT;
      HUNT: begin
        if (timeout)             state_d = IDLE;
        else if (sample && mark) state_d = COLLECT;
      end
      COLLECT: begin
        if (timeout) state_d = IDLE;
        else if (sample && !mark && (idx_q == IW'(LEN))) state_d = HUNT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    realign    = 1'b0;
    store      = 1'b0;
    frame_done = 1'b0;
    sync_evt   = 1'b0;
    case (state_q)
      HUNT: if (!timeout && sample && mark) realign = 1'b1;
      COLLECT: begin
        if (!timeout && sample) begin
          if (mark) begin
            realign = 1'b1;
            if (idx_q == IW'(LEN)) frame_done = 1'b1;
            else                   sync_evt   = 1'b1;
          end else if (idx_q == IW'(LEN)) begin
            sync_evt = 1'b1;
          end else begin
            store = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge mCLK or negedge nRST) begin
    if (!nRST) begin
      idx_q     <= '0;
      shadow_q  <= '0;
      MASK      <= '0;
      VALID     <= 1'b0;
      LOCKED    <= 1'b0;
      SYNC_ERR  <= 1'b0;
      have_prev <= 1'b0;
    end else begin
      VALID <= 1'b0;
      if (timeout) begin
        idx_q     <= '0;
        LOCKED    <= 1'b0;
        have_prev <= 1'b0;
      end else begin
        if (realign) begin
          shadow_q <= {{(LEN-1){1'b0}}, bit_v};
          idx_q    <= IW'(1);
        end else if (store) begin
          for (int i = 0; i < LEN; i++)
            if (idx_q == IW'(i)) shadow_q[i] <= bit_v;
          idx_q <= idx_q + IW'(1);
        end
        if (frame_done) begin
          MASK      <= shadow_q;
          VALID     <= 1'b1;
          LOCKED    <= have_prev && (shadow_q == MASK);
          have_prev <= 1'b1;
        end
        // Any misalignment restarts lock qualification from scratch.
        if (sync_evt) begin
          SYNC_ERR  <= 1'b1;
          LOCKED    <= 1'b0;
          have_prev <= 1'b0;
        end
      end
    end
  end

`ifdef SKIP_DECODE_CNT_EN
  function automatic logic [CW-1:0] popcnt(input logic [LEN-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < LEN; i++) c = c + CW'(v[i]);
    return c;
  endfunction

  always_ff @(posedge mCLK or negedge nRST) begin
    if (!nRST)           SKIP_CNT <= '0;
    else if (frame_done) SKIP_CNT <= popcnt(shadow_q);
  end
`else
  assign SKIP_CNT = '0;
`endif

endmodule

// File: tb/tb_skip_decode.sv
// Directed bench for skip_decode: LEN=4, SAMPLE_DLY=2, TIMEOUT=64, REF period 16 mCLK.
module tb_skip_decode;
  import skip_pkg::*;

  localparam int LEN  = 4;
  localparam int DLY  = 2;
  localparam int TO   = 64;
  localparam int HALF = 8;
`ifdef SKIP_DECODE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       mCLK = 1'b0, nRST = 1'b0, REF_CLK = 1'b0, SCLK = 1'b0, B0 = 1'b0;
  logic [3:0] MASK;
  logic       VALID, LOCKED, SYNC_ERR;
  logic [2:0] SKIP_CNT;

  int checks = 0, errors = 0, valid_cnt = 0;

  always #5 mCLK = ~mCLK;

  skip_decode #(.LEN(LEN), .SAMPLE_DLY(DLY), .TIMEOUT(TO)) dut (
    .mCLK(mCLK), .nRST(nRST), .REF_CLK(REF_CLK), .SCLK(SCLK), .B0(B0),
    .MASK(MASK), .VALID(VALID), .LOCKED(LOCKED), .SYNC_ERR(SYNC_ERR), .SKIP_CNT(SKIP_CNT)
  );

  always @(negedge mCLK) if (VALID === 1'b1) valid_cnt++;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  // One REF period: returns the negedge index (1..15) at which VALID was first seen, 0 if none.
  task automatic send_pos(input logic skip, input logic mark, output int vat);
    vat = 0;
    @(negedge mCLK);
    REF_CLK = 1'b1; SCLK = ~skip; B0 = mark;
    for (int k = 1; k < 16; k++) begin
      @(negedge mCLK);
      if (VALID === 1'b1 && vat == 0) vat = k;
      if (k == HALF) begin REF_CLK = 1'b0; SCLK = 1'b0; end
    end
  endtask

  task automatic send_frame(input logic [3:0] m, output int vat0);
    int v;
    vat0 = 0;
    for (int i = 0; i < LEN; i++) begin
      send_pos(m[i], (i == 0), v);
      if (i == 0) vat0 = v;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge mCLK);
    checks++; if (MASK !== 4'b0) begin errors++; $display("FAIL reset_mask: got %b want 0000", MASK); end
    checks++; if (VALID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", VALID); end
    checks++; if (LOCKED !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", LOCKED); end
    checks++; if (SYNC_ERR !== 1'b0) begin errors++; $display("FAIL reset_sync_err: got %b want 0", SYNC_ERR); end
    checks++; if (SKIP_CNT !== 3'd0) begin errors++; $display("FAIL reset_skip_cnt: got %0d want 0", SKIP_CNT); end
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", dut.state_q, IDLE); end
    nRST = 1'b1;
    repeat (4) @(negedge mCLK);
  endtask

  task automatic test_lock();
    int v0, v1, v2, vc;
    vc = valid_cnt;
    send_frame(4'b1010, v0);
    checks++; if (v0 !== 0) begin errors++; $display("FAIL lock_first_no_valid: valid at %0d want none", v0); end
    send_frame(4'b1010, v1);
    checks++; if (v1 !== DLY + 3) begin errors++; $display("FAIL lock_latency: valid at %0d want %0d", v1, DLY + 3); end
    checks++; if (MASK !== 4'b1010) begin errors++; $display("FAIL lock_mask1: got %b want 1010", MASK); end
    checks++; if (LOCKED !== 1'b0) begin errors++; $display("FAIL lock_not_yet: got %b want 0", LOCKED); end
    send_frame(4'b1010, v2);
    checks++; if (valid_cnt - vc !== 2) begin errors++; $display("FAIL lock_valid_count: got %0d want 2", valid_cnt - vc); end
    checks++; if (MASK !== 4'b1010) begin errors++; $display("FAIL lock_mask2: got %b want 1010", MASK); end
    checks++; if (LOCKED !== 1'b1) begin errors++; $display("FAIL lock_locked: got %b want 1", LOCKED); end
    checks++; if (SKIP_CNT !== (CNT_EN ? 3'd2 : 3'd0)) begin errors++; $display("FAIL lock_skip_cnt: got %0d want %0d", SKIP_CNT, CNT_EN ? 2 : 0); end
  endtask

  task automatic test_change();
    int v, vc;
    vc = valid_cnt;
    send_frame(4'b0000, v);
    checks++; if (LOCKED !== 1'b1) begin errors++; $display("FAIL change_hold_lock: got %b want 1", LOCKED); end
    send_frame(4'b0110, v);
    checks++; if (MASK !== 4'b0000) begin errors++; $display("FAIL change_mask0: got %b want 0000", MASK); end
    checks++; if (LOCKED !== 1'b0) begin errors++; $display("FAIL change_drop: got %b want 0", LOCKED); end
    send_frame(4'b0110, v);
    checks++; if (MASK !== 4'b0110) begin errors++; $display("FAIL change_mask1: got %b want 0110", MASK); end
    checks++; if (LOCKED !== 1'b0) begin errors++; $display("FAIL change_still_unlocked: got %b want 0", LOCKED); end
    send_frame(4'b0110, v);
    checks++; if (LOCKED !== 1'b1) begin errors++; $display("FAIL change_relock: got %b want 1", LOCKED); end
    checks++; if (valid_cnt - vc !== 4) begin errors++; $display("FAIL change_valid_count: got %0d want 4", valid_cnt - vc); end
  endtask

  task automatic test_sync_err();
    int v, vc;
    vc = valid_cnt;
    send_pos(1'b1, 1'b1, v);
    send_pos(1'b0, 1'b0, v);
    send_pos(1'b1, 1'b1, v);
    checks++; if (SYNC_ERR !== 1'b1) begin errors++; $display("FAIL syncerr_set: got %b want 1", SYNC_ERR); end
    checks++; if (LOCKED !== 1'b0) begin errors++; $display("FAIL syncerr_unlock: got %b want 0", LOCKED); end
    checks++; if (valid_cnt - vc !== 1) begin errors++; $display("FAIL syncerr_no_partial: got %0d want 1", valid_cnt - vc); end
    send_pos(1'b0, 1'b0, v);
    send_pos(1'b0, 1'b0, v);
    send_pos(1'b1, 1'b0, v);
    send_frame(4'b1001, v);
    checks++; if (valid_cnt - vc !== 2) begin errors++; $display("FAIL syncerr_recover_valid: got %0d want 2", valid_cnt - vc); end
    checks++; if (MASK !== 4'b1001) begin errors++; $display("FAIL syncerr_recover_mask: got %b want 1001", MASK); end
    checks++; if (SYNC_ERR !== 1'b1) begin errors++; $display("FAIL syncerr_sticky: got %b want 1", SYNC_ERR); end
    send_frame(4'b1001, v);
    checks++; if (LOCKED !== 1'b1) begin errors++; $display("FAIL syncerr_relock: got %b want 1", LOCKED); end
  endtask

  task automatic test_timeout();
    int vc;
    vc = valid_cnt;
    repeat (30) @(negedge mCLK);
    checks++; if (dut.state_q !== COLLECT) begin errors++; $display("FAIL timeout_early_state: got %0d want %0d", dut.state_q, COLLECT); end
    checks++; if (LOCKED !== 1'b1) begin errors++; $display("FAIL timeout_early_lock: got %b want 1", LOCKED); end
    repeat (40) @(negedge mCLK);
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL timeout_state: got %0d want %0d", dut.state_q, IDLE); end
    checks++; if (LOCKED !== 1'b0) begin errors++; $display("FAIL timeout_lock: got %b want 0", LOCKED); end
    checks++; if (MASK !== 4'b1001) begin errors++; $display("FAIL timeout_mask_held: got %b want 1001", MASK); end
    checks++; if (valid_cnt !== vc) begin errors++; $display("FAIL timeout_no_valid: got %0d want %0d", valid_cnt, vc); end
  endtask

  task automatic test_reset_mid();
    int v, vc;
    send_pos(1'b0, 1'b1, v);
    send_pos(1'b1, 1'b0, v);
    @(negedge mCLK);
    REF_CLK = 1'b1; SCLK = 1'b0; B0 = 1'b0;
    repeat (3) @(negedge mCLK);
    nRST = 1'b0;
    #1;
    checks++; if (MASK !== 4'b0) begin errors++; $display("FAIL rstmid_mask: got %b want 0000", MASK); end
    checks++; if (SYNC_ERR !== 1'b0) begin errors++; $display("FAIL rstmid_sync_err: got %b want 0", SYNC_ERR); end
    checks++; if (LOCKED !== 1'b0 || VALID !== 1'b0) begin errors++; $display("FAIL rstmid_lock_valid: got %b%b want 00", LOCKED, VALID); end
    checks++; if (SKIP_CNT !== 3'd0) begin errors++; $display("FAIL rstmid_skip_cnt: got %0d want 0", SKIP_CNT); end
    repeat (4) @(negedge mCLK);
    REF_CLK = 1'b0; SCLK = 1'b0;
    repeat (2) @(negedge mCLK);
    nRST = 1'b1;
    repeat (6) @(negedge mCLK);
    vc = valid_cnt;
    send_frame(4'b1110, v);
    checks++; if (v !== 0) begin errors++; $display("FAIL rstmid_first_no_valid: valid at %0d want none", v); end
    send_frame(4'b1110, v);
    checks++; if (MASK !== 4'b1110) begin errors++; $display("FAIL rstmid_mask: got %b want 1110", MASK); end
    checks++; if (LOCKED !== 1'b0) begin errors++; $display("FAIL rstmid_not_yet: got %b want 0", LOCKED); end
    checks++; if (SKIP_CNT !== (CNT_EN ? 3'd3 : 3'd0)) begin errors++; $display("FAIL rstmid_skip_cnt3: got %0d want %0d", SKIP_CNT, CNT_EN ? 3 : 0); end
    send_frame(4'b1110, v);
    checks++; if (LOCKED !== 1'b1) begin errors++; $display("FAIL rstmid_relock: got %b want 1", LOCKED); end
    checks++; if (valid_cnt - vc !== 2) begin errors++; $display("FAIL rstmid_valid_count: got %0d want 2", valid_cnt - vc); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_change();
    test_sync_err();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
